// File: rtl/hdc_feature_window.sv
// Sliding-window feature assembler: shifts accepted feature vectors through WINDOW_DEPTH
// slots and presents them newest-first as one wide window with a valid/ready handshake.
`timescale 1ns/1ps
module hdc_feature_window #(
    parameter int NUM_CHANNEL   = 214,
    parameter int CHANNEL_WIDTH = 8,
    parameter int WINDOW_DEPTH  = 3,
    parameter int ZERO_FILL     = 1,
    localparam int FW = NUM_CHANNEL * CHANNEL_WIDTH,
    localparam int CW = $clog2(WINDOW_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [FW-1:0]              feature_in,
    input  logic                       fin_valid,
    output logic                       fin_ready,
    output logic [WINDOW_DEPTH*FW-1:0] features_top,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [CW-1:0]              fill_count,
    output logic [15:0]                window_count
);

    localparam logic [CW-1:0] DEPTH = CW'(WINDOW_DEPTH);

    logic [FW-1:0] slots [WINDOW_DEPTH];
    logic          acc;
    logic          del;
    logic [CW-1:0] fill_next;

    // Ready passes straight through from downstream so a full-rate stream never stalls.
    assign fin_ready = ~rst & ~clear & (~dout_valid | dout_ready);
    assign acc       = fin_valid & fin_ready;
    assign del       = dout_valid & dout_ready;
    assign fill_next = (fill_count == DEPTH) ? DEPTH : fill_count + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WINDOW_DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < WINDOW_DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else if (acc) begin
            slots[0] <= feature_in;
            for (int k = 1; k < WINDOW_DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

    // Without zero fill the window only becomes valid once every slot holds a real sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_count   <= '0;
            dout_valid   <= 1'b0;
            window_count <= '0;
        end else if (clear) begin
            fill_count   <= '0;
            dout_valid   <= 1'b0;
            window_count <= '0;
        end else begin
            if (acc) begin
                fill_count <= fill_next;
                dout_valid <= (ZERO_FILL != 0) || (fill_next == DEPTH);
            end else if (del) begin
                dout_valid <= 1'b0;
            end
            if (del) begin
                window_count <= window_count + 16'd1;
            end
        end
    end

    for (genvar k = 0; k < WINDOW_DEPTH; k++) begin : g_slot
        assign features_top[(WINDOW_DEPTH-k)*FW-1 -: FW] = slots[k];
    end

endmodule

// File: doc/hdc_feature_window.md
Name: hdc_feature_window

Overview:
Parametrised sliding-window feature assembler placed in front of hdc_sensor_fusion. It accepts one feature vector per valid/ready handshake. It emits a concatenated window of the WINDOW_DEPTH most recent vectors, newest in the MSB slot, on the features_top bus. This replaces host-side window construction and generalises the fixed 3-deep window to any depth. It adds a zero-fill/warm-up mode selection and a synchronous history flush.

Parameters:
NUM_CHANNEL, 214, number of channels per feature vector
CHANNEL_WIDTH, 8, bits per channel
WINDOW_DEPTH, 3, number of vectors per output window (>=2)
ZERO_FILL, 1, 1: emit from the first sample with older slots zero; 0: suppress output until WINDOW_DEPTH samples are held
Derived: FW = NUM_CHANNEL*CHANNEL_WIDTH; CW = ceilLog2(WINDOW_DEPTH+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous flush of window history
feature_in  in  FW  newest feature vector
fin_valid  in  1  feature_in valid
fin_ready  out  1  block can accept feature_in
features_top  out  WINDOW_DEPTH*FW  window; slot k at bits [(WINDOW_DEPTH-k)*FW-1 -: FW], k=0 newest
dout_valid  out  1  features_top valid
dout_ready  in  1  downstream accepts window
fill_count  out  CW  samples held, saturates at WINDOW_DEPTH
window_count  out  16  windows delivered since reset/clear, wraps at 2^16

Behaviour:
- Reset (async, rst=1): all history slots 0, features_top=0, dout_valid=0, fill_count=0, window_count=0; fin_ready=0 while rst is high.
- Storage: WINDOW_DEPTH registers slot[0..D-1]. features_top is the direct concatenation {slot[0],...,slot[D-1]}.
- Accept: acc = fin_valid & fin_ready. On acc: slot[k]<=slot[k-1] for k>=1; slot[0]<=feature_in; fill_count<=min(fill_count+1, D).
- Output valid:
  - ZERO_FILL=1: dout_valid<=1 on every acc.
  - ZERO_FILL=0: dout_valid<=1 on acc only if the post-update fill_count==D; otherwise dout_valid stays 0 (warm-up, no handshake needed).
- Latency: window containing a vector is valid the cycle after its acceptance edge (1 cycle).
- fin_ready = ~rst & ~clear & (~dout_valid | dout_ready). This is combinational pass-through ready, giving one accept per cycle at full throughput.
- Output handshake: del = dout_valid & dout_ready.
  - On del without acc: dout_valid<=0.
  - On del and acc in the same cycle: dout_valid stays 1 with the new window.
  - window_count increments on every del.
- features_top and dout_valid are held stable while dout_valid=1 and dout_ready=0. History cannot change because fin_ready=0.
- clear (sync, highest priority over acc/del): slots<=0, fill_count<=0, dout_valid<=0, window_count<=0. Any pending window is discarded even if dout_ready=1 that cycle. Clear does not count as a delivery.
- fill_count saturation: after D accepts it stays at D. The oldest slot is dropped on each further accept.
- Reset mid-window: outputs go to reset values immediately (async). First accept after deassertion behaves as the first sample.
- No internal FSM beyond the states {EMPTY/WARMUP, HOLD (dout_valid=1), IDLE_FULL}, which are implied by fill_count and dout_valid.

Test Plan:
All scenarios use NUM_CHANNEL=2, CHANNEL_WIDTH=4, WINDOW_DEPTH=3.
- ZERO_FILL=1, dout_ready=1, send 8'h11, 8'h22, 8'h33, 8'h44 back-to-back -> windows 24'h110000, 24'h221100, 24'h332211, 24'h443322, each one cycle after its accept; fin_ready constant 1; window_count=4.
- ZERO_FILL=0, same stimulus -> dout_valid low for the first two accepts; windows 24'h332211 and 24'h443322 only; fill_count sequence 1,2,3,3.
- Backpressure: dout_ready=0 for 5 cycles with a window pending -> fin_ready=0, features_top and dout_valid stable for all 5 cycles; next vector 8'h55 is accepted only in the cycle dout_ready=1, giving dout_valid continuously 1 and window 24'h554433.
- clear asserted while dout_valid=1 and dout_ready=1 -> next cycle dout_valid=0, fill_count=0, window_count=0, features_top=0; next accepted 8'h66 gives 24'h660000 (ZERO_FILL=1).
- Async reset pulse mid-stream (not clock-aligned) -> all outputs 0 before the next clk edge; stream restarts with zero-filled windows.
- Random valid/ready gaps (0-15 cycles), 20 vectors -> every window matches a software shift-register model; no window is lost or duplicated; window_count=20.
